// File: rtl/pe_mac_stream.sv
// -----------------------------------------------------------------------------
// pe_mac_stream
//
// Systolic processing element for the LSTM datapath array. The up and left
// operand streams are forwarded down and right with one cycle of latency. When
// both operands are valid they are multiplied and the product is accumulated.
// A last flag on the left stream closes the dot product. The finished sum goes
// into a one-deep output buffer, which is drained with a valid/ready handshake.
//
// Optional feature: define PE_SAT_EN to make the accumulator saturate to the
// ACC_WIDTH range instead of wrapping modulo 2^ACC_WIDTH.
//
// Handshake: a result transfers on any rising edge where acc_valid=1 and
// acc_ready=1. acc_out is stable while acc_valid=1 and acc_ready=0. A result
// arriving while the buffer is full and not being drained is dropped, and this
// sets ovf_err.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   en                       array advance enable (freezes forwarding + MAC)
//   up_data/up_valid         operand from the PE above
//   left_data/left_valid     operand from the PE to the left
//   left_last                closes the current dot product
//   down_data/down_valid     registered copy of the up stream
//   right_data/right_valid/right_last  registered copy of the left stream
//   acc_out/acc_valid        completed dot-product result (acc_valid = buffer FULL)
//   acc_ready                consumer accepts acc_out this cycle
//   ovf_err                  sticky: a finished result was dropped
// -----------------------------------------------------------------------------
module pe_mac_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int SIGNED_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic                  left_valid,
    input  logic                  left_last,
    output logic [DATA_WIDTH-1:0] down_data,
    output logic                  down_valid,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  right_valid,
    output logic                  right_last,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  ovf_err
);

    // The output buffer state is exposed directly as acc_valid.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] down_data_q, down_data_d;
    logic                  down_valid_q, down_valid_d;
    logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
    logic                  right_valid_q, right_valid_d;
    logic                  right_last_q, right_last_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic                  ovf_err_q, ovf_err_d;

    // ---------------------------------------------------------------------
    // Datapath: product, extension, accumulate
    // ---------------------------------------------------------------------
    logic                           fire;
    logic                           close;
    logic                           buf_free;
    logic signed [DATA_WIDTH-1:0]   up_s;
    logic signed [DATA_WIDTH-1:0]   left_s;
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0]        prod_u;
    logic [ACC_WIDTH-1:0]           prod_ext;
    logic [ACC_WIDTH-1:0]           sum;

    assign fire  = en & up_valid & left_valid;
    assign close = fire & left_last;
    // A closing result can be accepted if the buffer is empty or is being
    // drained in this same cycle.
    assign buf_free = (state_q == BUF_EMPTY) || acc_ready;

    assign up_s   = $signed(up_data);
    assign left_s = $signed(left_data);

    always_comb begin
        prod_s = up_s * left_s;
        prod_u = {{DATA_WIDTH{1'b0}}, up_data} * {{DATA_WIDTH{1'b0}}, left_data};
        // Fill the upper bits first, then overlay the full-width product.
        if (SIGNED_MODE != 0) begin
            prod_ext                   = {ACC_WIDTH{prod_s[2*DATA_WIDTH-1]}};
            prod_ext[2*DATA_WIDTH-1:0] = prod_s;
        end else begin
            prod_ext                   = '0;
            prod_ext[2*DATA_WIDTH-1:0] = prod_u;
        end
    end

`ifdef PE_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};

    logic [ACC_WIDTH:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
        sum      = sum_wide[ACC_WIDTH-1:0];
        if (SIGNED_MODE != 0) begin
            // Signed overflow: both addends share a sign that the result lost.
            if ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                (sum_wide[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) begin
                sum = acc_q[ACC_WIDTH-1] ? SMIN : SMAX;
            end
        end else begin
            if (sum_wide[ACC_WIDTH]) begin
                sum = UMAX;
            end
        end
    end
`else
    assign sum = acc_q + prod_ext;
`endif

    // ---------------------------------------------------------------------
    // FSM process 1: state register (plus all other flops)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BUF_EMPTY;
            down_data_q   <= '0;
            down_valid_q  <= 1'b0;
            right_data_q  <= '0;
            right_valid_q <= 1'b0;
            right_last_q  <= 1'b0;
            acc_q         <= '0;
            acc_out_q     <= '0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            down_data_q   <= down_data_d;
            down_valid_q  <= down_valid_d;
            right_data_q  <= right_data_d;
            right_valid_q <= right_valid_d;
            right_last_q  <= right_last_d;
            acc_q         <= acc_d;
            acc_out_q     <= acc_out_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 2: next-state and datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUF_EMPTY: if (close) state_d = BUF_FULL;
            BUF_FULL: begin
                if (close)          state_d = BUF_FULL;
                else if (acc_ready) state_d = BUF_EMPTY;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        down_data_d   = down_data_q;
        down_valid_d  = down_valid_q;
        right_data_d  = right_data_q;
        right_valid_d = right_valid_q;
        right_last_d  = right_last_q;
        acc_d         = acc_q;
        acc_out_d     = acc_out_q;
        ovf_err_d     = ovf_err_q;

        // Data registers load regardless of valid so they stay deterministic.
        if (en) begin
            down_data_d   = up_data;
            down_valid_d  = up_valid;
            right_data_d  = left_data;
            right_valid_d = left_valid;
            right_last_d  = left_last;
        end

        if (fire) begin
            acc_d = left_last ? '0 : sum;
        end

        if (close) begin
            if (buf_free) begin
                acc_out_d = sum;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 3: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        acc_valid = (state_q == BUF_FULL);
    end

    assign down_data   = down_data_q;
    assign down_valid  = down_valid_q;
    assign right_data  = right_data_q;
    assign right_valid = right_valid_q;
    assign right_last  = right_last_q;
    assign acc_out     = acc_out_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_pe_mac_stream.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_stream
//
// Directed bench for pe_mac_stream. The main instance is signed with a 16-bit
// accumulator, so the wrap/saturation case is reachable. A second instance is
// unsigned, to show that the same operand bits give a different product.
// Inputs change 1 time unit after a rising edge, and outputs are checked
// there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pe_mac_stream;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic          en;
  logic [DW-1:0] up_data;
  logic          up_valid;
  logic [DW-1:0] left_data;
  logic          left_valid;
  logic          left_last;
  logic [DW-1:0] down_data;
  logic          down_valid;
  logic [DW-1:0] right_data;
  logic          right_valid;
  logic          right_last;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          ovf_err;

  logic [DW-1:0] u_up_data;
  logic          u_up_valid;
  logic [DW-1:0] u_left_data;
  logic          u_left_valid;
  logic          u_left_last;
  logic [DW-1:0] u_down_data;
  logic          u_down_valid;
  logic [DW-1:0] u_right_data;
  logic          u_right_valid;
  logic          u_right_last;
  logic [AW-1:0] u_acc_out;
  logic          u_acc_valid;
  logic          u_acc_ready;
  logic          u_ovf_err;

  int checks;
  int failures;

  logic [AW-1:0] exp_ovf;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pe_mac_stream #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .SIGNED_MODE(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .left_data  (left_data),
    .left_valid (left_valid),
    .left_last  (left_last),
    .down_data  (down_data),
    .down_valid (down_valid),
    .right_data (right_data),
    .right_valid(right_valid),
    .right_last (right_last),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf_err    (ovf_err)
  );

  pe_mac_stream #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .SIGNED_MODE(0)
  ) dut_u (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_data    (u_up_data),
    .up_valid   (u_up_valid),
    .left_data  (u_left_data),
    .left_valid (u_left_valid),
    .left_last  (u_left_last),
    .down_data  (u_down_data),
    .down_valid (u_down_valid),
    .right_data (u_right_data),
    .right_valid(u_right_valid),
    .right_last (u_right_last),
    .acc_out    (u_acc_out),
    .acc_valid  (u_acc_valid),
    .acc_ready  (u_acc_ready),
    .ovf_err    (u_ovf_err)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] u, input logic uv,
                       input logic [DW-1:0] l, input logic lv, input logic last);
    up_data    = u;
    up_valid   = uv;
    left_data  = l;
    left_valid = lv;
    left_last  = last;
  endtask

  // comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    en           = 1'b0;
    acc_ready    = 1'b0;
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    u_up_data    = 8'd0;
    u_up_valid   = 1'b0;
    u_left_data  = 8'd0;
    u_left_valid = 1'b0;
    u_left_last  = 1'b0;
    u_acc_ready  = 1'b0;
`ifdef PE_SAT_EN
    exp_ovf = 16'h7FFF;     // clamps at +32767
`else
    exp_ovf = 16'hBD03;     // 48387 mod 65536 = -17149
`endif

    // ---- reset state ----
    tick();
    tick();
    chk("rst_down_data", down_data, 0);
    chk("rst_down_valid", down_valid, 0);
    chk("rst_right_data", right_data, 0);
    chk("rst_right_valid", right_valid, 0);
    chk("rst_right_last", right_last, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_ovf_err", ovf_err, 0);
    reset = 1'b0;
    en    = 1'b1;

    // ---- single-term dot product 5*3 ----
    drive(8'd5, 1'b1, 8'd3, 1'b1, 1'b1);
    tick();
    chk("t1_acc_out", acc_out, 15);
    chk("t1_acc_valid", acc_valid, 1);
    chk("t1_down_data", down_data, 5);
    chk("t1_down_valid", down_valid, 1);
    chk("t1_right_data", right_data, 3);
    chk("t1_right_valid", right_valid, 1);
    chk("t1_right_last", right_last, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    acc_ready = 1'b1;
    tick();
    chk("t1_drain_valid", acc_valid, 0);
    chk("t1_drain_hold", acc_out, 15);

    // ---- signed 3-term: -2*4 + 3*3 + -1*-7 = 8 ----
    drive(8'hFE, 1'b1, 8'd4, 1'b1, 1'b0);
    tick();
    chk("t2_mid_valid", acc_valid, 0);
    drive(8'd3, 1'b1, 8'd3, 1'b1, 1'b0);
    tick();
    drive(8'hFF, 1'b1, 8'hF9, 1'b1, 1'b1);
    tick();
    chk("t2_acc_out", acc_out, 8);
    chk("t2_acc_valid", acc_valid, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("t2_one_cycle", acc_valid, 0);
    drive(8'd2, 1'b1, 8'd2, 1'b1, 1'b1);
    tick();
    chk("t2_restart_out", acc_out, 4);
    chk("t2_restart_valid", acc_valid, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();

    // ---- back-pressure: A=10 held, B=20 dropped ----
    acc_ready = 1'b0;
    drive(8'd2, 1'b1, 8'd5, 1'b1, 1'b1);
    tick();
    chk("t3_a_out", acc_out, 10);
    chk("t3_a_ovf", ovf_err, 0);
    drive(8'd4, 1'b1, 8'd5, 1'b1, 1'b1);
    tick();
    chk("t3_b_hold_out", acc_out, 10);
    chk("t3_b_hold_valid", acc_valid, 1);
    chk("t3_b_ovf", ovf_err, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    acc_ready = 1'b1;
    tick();
    chk("t3_drain_valid", acc_valid, 0);
    chk("t3_ovf_sticky", ovf_err, 1);
    reset = 1'b1;
    tick();
    chk("t3_ovf_reset", ovf_err, 0);
    reset = 1'b0;

    // ---- same-cycle drain and refill ----
    acc_ready = 1'b0;
    drive(8'd2, 1'b1, 8'd5, 1'b1, 1'b1);
    tick();
    chk("t4_full_out", acc_out, 10);
    acc_ready = 1'b1;
    drive(8'd7, 1'b1, 8'd1, 1'b1, 1'b1);
    tick();
    chk("t4_refill_out", acc_out, 7);
    chk("t4_refill_valid", acc_valid, 1);
    chk("t4_refill_ovf", ovf_err, 0);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("t4_drain_valid", acc_valid, 0);

    // ---- stall: 3*4 | en=0 ignores 9*9 last | 2*5 last -> 22 ----
    acc_ready = 1'b0;
    drive(8'd3, 1'b1, 8'd4, 1'b1, 1'b0);
    tick();
    chk("t5_down_data", down_data, 3);
    en = 1'b0;
    drive(8'd9, 1'b1, 8'd9, 1'b1, 1'b1);
    tick();
    chk("t5_stall_down", down_data, 3);
    chk("t5_stall_right", right_data, 4);
    chk("t5_stall_last", right_last, 0);
    chk("t5_stall_valid", acc_valid, 0);
    tick();
    chk("t5_stall_down_valid", down_valid, 1);
    en = 1'b1;
    drive(8'd2, 1'b1, 8'd5, 1'b1, 1'b1);
    tick();
    chk("t5_resume_out", acc_out, 22);
    chk("t5_resume_valid", acc_valid, 1);
    en = 1'b0;
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    acc_ready = 1'b1;
    tick();
    chk("t5_drain_when_stalled", acc_valid, 0);
    en = 1'b1;

    // ---- reset mid dot product ----
    drive(8'd6, 1'b1, 8'd6, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    drive(8'd6, 1'b1, 8'd6, 1'b1, 1'b1);
    tick();
    chk("t6_rst_down_data", down_data, 0);
    chk("t6_rst_down_valid", down_valid, 0);
    chk("t6_rst_right_data", right_data, 0);
    chk("t6_rst_right_valid", right_valid, 0);
    chk("t6_rst_right_last", right_last, 0);
    chk("t6_rst_acc_out", acc_out, 0);
    chk("t6_rst_acc_valid", acc_valid, 0);
    reset = 1'b0;
    drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b1);
    tick();
    chk("t6_after_rst_out", acc_out, 1);
    chk("t6_after_rst_valid", acc_valid, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();

    // ---- accumulator overflow: 3 x 127*127, one-sided beat in between ----
    drive(8'd127, 1'b1, 8'd127, 1'b1, 1'b0);
    tick();
    tick();
    drive(8'd50, 1'b1, 8'd3, 1'b0, 1'b1);
    tick();
    chk("t7_one_side_valid", acc_valid, 0);
    drive(8'd127, 1'b1, 8'd127, 1'b1, 1'b1);
    tick();
    chk("t7_ovf_out", acc_out, exp_ovf);
    chk("t7_ovf_valid", acc_valid, 1);
    drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick();

    // ---- signed vs unsigned: 0xFF*0xFF ----
    drive(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    u_up_data    = 8'hFF;
    u_up_valid   = 1'b1;
    u_left_data  = 8'hFF;
    u_left_valid = 1'b1;
    u_left_last  = 1'b1;
    tick();
    chk("t8_signed_out", acc_out, 1);
    chk("t8_unsigned_out", u_acc_out, 16'hFE01);
    chk("t8_unsigned_valid", u_acc_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
